// File: rtl/divider.sv
// rtl/divider.sv - iterative 32-bit restoring divider sharing the execute-stage ALU
// DIV/DIVU: lo = quotient, hi = remainder; one ALU subtraction per RUN cycle.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        DivE,
  input  logic        SignedE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [31:0] ALUOut,
  input  logic        ALU_zero,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [2:0]  ALU_f,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        completed
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] shifted, mag_a, mag_b;
  logic        borrow, fits;
  logic        unused_alu_zero;

  assign unused_alu_zero = ALU_zero;

  assign shifted = {r_q[30:0], q_q[31]};
  // Unsigned borrow of shifted - D, recovered from the ALU's result sign.
  assign borrow  = (~shifted[31] & d_q[31]) | (~(shifted[31] ^ d_q[31]) & ALUOut[31]);
  assign fits    = r_q[31] | ~borrow;

  assign mag_a = (SignedE & SrcAE[31]) ? -SrcAE : SrcAE;
  assign mag_b = (SignedE & SrcBE[31]) ? -SrcBE : SrcBE;

  assign ALU_A     = (state_q == RUN) ? shifted : 32'd0;
  assign ALU_B     = (state_q == RUN) ? d_q : 32'd0;
  assign ALU_f     = 3'b110;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign completed = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (DivE) begin
          if (SrcBE == 32'd0) begin
            hi_d    = SrcAE;
            lo_d    = 32'hFFFF_FFFF;
            state_d = DONE;
          end else begin
            q_d     = mag_a;
            d_d     = mag_b;
            r_d     = 32'd0;
            cnt_d   = 5'd0;
            negq_d  = SignedE & (SrcAE[31] ^ SrcBE[31]);
            negr_d  = SignedE & SrcAE[31];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = fits ? ALUOut : shifted;
        q_d   = {q_q[30:0], fits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        lo_d    = negq_q ? -q_q : q_q;
        hi_d    = negr_q ? -r_q : r_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= 32'd0;
      q_q     <= 32'd0;
      d_q     <= 32'd0;
      cnt_q   <= 5'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider
// Arithmetic reference model plus directed vectors with literal expectations.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        DivE, SignedE;
  logic [31:0] SrcAE, SrcBE, ALUOut, ALU_A, ALU_B, hi, lo;
  logic        ALU_zero, completed;
  logic [2:0]  ALU_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ALUOut   = ALU_A - ALU_B;
  assign ALU_zero = (ALUOut == 32'd0);

  divider dut (
    .clk(clk), .rst(rst), .DivE(DivE), .SignedE(SignedE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUOut(ALUOut), .ALU_zero(ALU_zero),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_f(ALU_f),
    .hi(hi), .lo(lo), .completed(completed)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Quotient/remainder from magnitudes; avoids native signed overflow.
  task automatic model_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb, uq, ur;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    uq = ma / mb;
    ur = ma % mb;
    q  = (s && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    r  = (s && a[31]) ? (32'd0 - ur) : ur;
  endtask

  int          cyc, m_due, m_next_ok;
  bit          m_busy, exp_comp;
  logic [31:0] m_phi, m_plo, exp_hi, exp_lo;

  always @(posedge clk or negedge rst) begin
    logic [31:0] tq, tr;
    if (!rst) begin
      cyc       <= 0;
      m_busy    <= 1'b0;
      m_due     <= 0;
      m_next_ok <= 0;
      exp_hi    <= 32'd0;
      exp_lo    <= 32'd0;
      exp_comp  <= 1'b0;
    end else begin
      cyc      <= cyc + 1;
      exp_comp <= 1'b0;
      if (m_busy) begin
        if (cyc + 1 == m_due) begin
          exp_hi    <= m_phi;
          exp_lo    <= m_plo;
          exp_comp  <= 1'b1;
          m_busy    <= 1'b0;
          m_next_ok <= cyc + 3;
        end
      end else if (cyc + 1 >= m_next_ok && DivE) begin
        if (SrcBE == 32'd0) begin
          exp_hi    <= SrcAE;
          exp_lo    <= 32'hFFFF_FFFF;
          exp_comp  <= 1'b1;
          m_next_ok <= cyc + 3;
        end else begin
          model_div(SrcAE, SrcBE, SignedE, tq, tr);
          m_plo  <= tq;
          m_phi  <= tr;
          m_busy <= 1'b1;
          m_due  <= cyc + 34;
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_completed", {31'd0, completed}, {31'd0, exp_comp});
      chk("cmp_hi", hi, exp_hi);
      chk("cmp_lo", lo, exp_lo);
      chk("cmp_alu_f", {29'd0, ALU_f}, 32'd6);
      if (!m_busy) begin
        chk("cmp_alu_a_idle", ALU_A, 32'd0);
        chk("cmp_alu_b_idle", ALU_B, 32'd0);
      end
    end
  end

  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] elo, input logic [31:0] ehi,
                         input int elat, input bit scramble);
    int n;
    @(negedge clk); #1;
    SrcAE = a; SrcBE = b; SignedE = s; DivE = 1'b1;
    @(posedge clk); n = 1; #1;
    DivE = 1'b0;
    if (scramble) begin
      SrcAE = ~a; SrcBE = b + 32'd5; SignedE = ~s;
    end
    while (!completed && n < 100) begin
      @(posedge clk); n++; #1;
    end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_lo"}, lo, elo);
    chk({nm, "_hi"}, hi, ehi);
    @(posedge clk); #1;
    chk({nm, "_pulse_width"}, {31'd0, completed}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; DivE = 1'b0; SignedE = 1'b0; SrcAE = 32'd0; SrcBE = 32'd0;
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_completed", {31'd0, completed}, 32'd0);
    chk("reset_alu_a", ALU_A, 32'd0);
    chk("reset_alu_f", {29'd0, ALU_f}, 32'd6);
    @(negedge clk); #1 rst = 1'b1;
    cmp_en = 1'b1;

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 1'b0);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b0);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 34, 1'b0);
    run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
    run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 34, 1'b0);
    run_div("divu_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 34, 1'b0);
    run_div("div_by_zero", 32'd123, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd123, 1, 1'b0);
    run_div("stable_ops", 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 34, 1'b1);

    // Abort mid-operation.
    @(negedge clk); #1;
    SrcAE = 32'd1000; SrcBE = 32'd3; SignedE = 1'b0; DivE = 1'b1;
    @(posedge clk); #1 DivE = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_completed", {31'd0, completed}, 32'd0);
    chk("abort_alu_a", ALU_A, 32'd0);
    chk("abort_alu_b", ALU_B, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    run_div("after_abort", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 34, 1'b0);

    // DivE held high: second division starts at edge 36.
    @(negedge clk); #1;
    SrcAE = 32'd100; SrcBE = 32'd7; SignedE = 1'b0; DivE = 1'b1;
    @(posedge clk); n = 1; #1;
    while (!completed && n < 100) begin
      @(posedge clk); n++; #1;
    end
    chk("b2b_first_latency", n, 34);
    chk("b2b_first_lo", lo, 32'd14);
    chk("b2b_first_hi", hi, 32'd2);
    SrcAE = 32'd500; SrcBE = 32'd9;
    @(posedge clk); n++; #1;
    @(posedge clk); n++; #1;
    DivE = 1'b0;
    while (!completed && n < 150) begin
      @(posedge clk); n++; #1;
    end
    chk("b2b_second_latency", n, 69);
    chk("b2b_second_lo", lo, 32'd55);
    chk("b2b_second_hi", hi, 32'd5);
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
